// File: rtl/pht_ctrl.sv
`default_nettype none
// pht_ctrl: gshare lookup/training controller for a 2-bit PHT with an in-flight FIFO.
// Optional PHT_CTRL_STATS_EN adds prediction/mispredict counters.
module pht_ctrl #(
  parameter int IDX_SIZE = 4,
  parameter int WIDTH    = 2,
  parameter int GHR_LEN  = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_ready,
  output logic                pred_valid,
  output logic                pred_taken,
  input  logic                res_valid,
  input  logic                res_taken,
  output logic                res_ready,
  output logic                flush,
  output logic [GHR_LEN-1:0]  ghr,
  output logic [IDX_SIZE-1:0] pht_idx,
  output logic                pht_load,
  output logic [WIDTH-1:0]    pht_in,
  input  logic [WIDTH-1:0]    pht_out
`ifdef PHT_CTRL_STATS_EN
  ,
  output logic [31:0]         stat_preds,
  output logic [31:0]         stat_misp
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_SIZE-1:0] fifo_idx  [DEPTH];
  logic                fifo_pred [DEPTH];
  logic [GHR_LEN-1:0]  fifo_ghr  [DEPTH];

  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW:0]         count;

  logic                full;
  logic                update;
  logic                accept;
  logic                mispredict;
  logic [IDX_SIZE-1:0] pred_idx;
  logic [WIDTH-1:0]    cnt_next;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[31:IDX_SIZE+2], pred_pc[1:0]};

  assign full       = (count == (PW+1)'(DEPTH));
  assign res_ready  = (count != '0);
  assign update     = res_valid & res_ready;
  // Held low during reset so a pending request cannot drive the table index.
  assign pred_ready = rst & ~full & ~update;
  assign accept     = pred_req & pred_ready;
  assign mispredict = update & (fifo_pred[head] != res_taken);
  assign pred_idx   = pred_pc[IDX_SIZE+1:2] ^ IDX_SIZE'(ghr);

  always_comb begin
    cnt_next = pht_out;
    if (res_taken && (pht_out != '1))
      cnt_next = pht_out + 1'b1;
    else if (!res_taken && (pht_out != '0))
      cnt_next = pht_out - 1'b1;
  end

  always_comb begin
    pht_idx  = '0;
    pht_load = 1'b0;
    pht_in   = '0;
    if (update) begin
      pht_idx  = fifo_idx[head];
      pht_load = 1'b1;
      pht_in   = cnt_next;
    end else if (accept) begin
      pht_idx  = pred_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_idx[tail]  <= pred_idx;
      fifo_pred[tail] <= pht_out[WIDTH-1];
      fifo_ghr[tail]  <= ghr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      flush      <= 1'b0;
    end else begin
      pred_valid <= accept;
      pred_taken <= accept & pht_out[WIDTH-1];
      flush      <= mispredict;
      if (update) begin
        if (mispredict) begin
          // Rebuild history from the snapshot taken before this branch shifted in.
          ghr   <= {fifo_ghr[head][GHR_LEN-2:0], res_taken};
          head  <= tail;
          count <= '0;
        end else begin
          head  <= head + 1'b1;
          count <= count - 1'b1;
        end
      end else if (accept) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
        ghr   <= {ghr[GHR_LEN-2:0], pht_out[WIDTH-1]};
      end
    end
  end

`ifdef PHT_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_preds <= '0;
      stat_misp  <= '0;
    end else begin
      if (accept)     stat_preds <= stat_preds + 32'd1;
      if (mispredict) stat_misp  <= stat_misp + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/pht_ctrl.md
Name: pht_ctrl

Overview:
- Lookup/training controller on the other end of the pattern history table (PHT) port.
- Drives the table's single index, load and write-data lines; reads its combinational counter output.
- Forms gshare indices from the fetch PC and a speculative global history register (GHR).
- Keeps an in-order FIFO of in-flight predictions; trains 2-bit counters on execute-stage resolution; repairs the GHR on a mispredict.

Parameters:
- IDX_SIZE, 4, PHT index width (table has 2**IDX_SIZE entries).
- WIDTH, 2, counter width (must be 2).
- GHR_LEN, 4, global history bits (GHR_LEN <= IDX_SIZE).
- DEPTH, 4, in-flight FIFO entries (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_req  in  1  fetch requests a prediction.
- pred_pc  in  32  fetch PC.
- pred_ready  out  1  request accepted this cycle when pred_req & pred_ready.
- pred_valid  out  1  registered; prediction valid (1 cycle after accept).
- pred_taken  out  1  registered predicted direction.
- res_valid  in  1  oldest in-flight branch resolved.
- res_taken  in  1  actual direction.
- res_ready  out  1  equals FIFO non-empty.
- flush  out  1  registered 1-cycle pulse on mispredict.
- ghr  out  GHR_LEN  current speculative history.
- pht_idx  out  IDX_SIZE  table index (read and write).
- pht_load  out  1  table write enable.
- pht_in  out  WIDTH  counter write data.
- pht_out  in  WIDTH  combinational counter at pht_idx.

Behaviour:
- Index is pred_pc[IDX_SIZE+1:2] XOR {zero-pad, ghr}.
- FIFO entry holds {idx, predicted bit, GHR value before the shift}.
- One table access per cycle. Resolution has priority over prediction.
- pred_ready = !full & !(res_valid & res_ready).
- Update cycle (res_valid & res_ready):
  - pht_idx = head.idx; pht_load = 1.
  - pht_in = sat(pht_out): increment if res_taken, else decrement; saturate at 2'b11 and 2'b00.
  - Update uses the current table value, not a snapshot.
  - Head entry is popped.
- Predict cycle (accepted request):
  - pht_idx = computed index; pht_load = 0.
  - Next cycle: pred_valid = 1, pred_taken = pht_out[1].
  - Entry pushed; ghr <= {ghr[GHR_LEN-2:0], pht_out[1]}.
- Idle cycle:
  - pht_idx = 0; pht_load = 0; pred_valid = 0 next cycle.
- Mispredict (head.predicted != res_taken on an update):
  - Counter is still trained.
  - ghr <= {head.ghr[GHR_LEN-2:0], res_taken}.
  - Whole FIFO emptied (head and all younger entries); flush = 1 next cycle.
  - No prediction is accepted that cycle.
- Correct resolution: ghr unchanged; only the head is popped.
- Full FIFO: pred_ready = 0. Empty FIFO: res_ready = 0, and res_valid is ignored.
- Pointers wrap modulo DEPTH; count is a separate log2(DEPTH)+1-bit register.
- Reset (asserted any time, including mid-operation):
  - ghr = 0, FIFO empty, pred_valid = 0, pred_taken = 0, flush = 0.
  - pht_load = 0, pht_idx = 0, pht_in = 0.
  - pred_ready = 1 after release.
  - Table contents are not cleared by this block.

Optional Feature:
- Macro: PHT_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_preds (32) and stat_misp (32).
  - stat_preds increments per accepted prediction; stat_misp per mispredict.
  - Both wrap at 2**32 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, table all 00, pred_pc=0x10, ghr=0 -> pht_idx=4, next cycle pred_valid=1, pred_taken=0, ghr=0000.
- Resolve that branch with res_taken=1 -> pht_load=1, pht_idx=4, pht_in=01; mispredict: flush=1 next cycle, ghr=0001, FIFO empty.
- Four taken resolutions on the idx 4 counter starting at 00 -> pht_in sequence 01,10,11,11 (saturation); then not-taken -> 10.
- Accept 4 predictions without resolving -> pred_ready=0 on the 5th; res_ready=1; after one resolution pred_ready returns to 1.
- pred_req and res_valid in the same cycle, FIFO non-empty -> update wins, pred_ready=0, pht_idx=head.idx; request accepted the next cycle.
- Assert rst low mid-stream with 3 entries pending -> all outputs return to reset values immediately; res_ready=0.
